// File: rtl/app_mem_responder.sv
// ============================================================================
// app_mem_responder : block-RAM stand-in for the DDR controller app interface
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module app_mem_responder #(
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 64,
    parameter int RD_LATENCY  = 2,
    parameter int THROTTLE    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [26:0] app_addr_i,
    input  logic        app_wr_valid_i,
    output logic        app_wr_rdy_o,
    input  logic [15:0] app_wr_payload_i,
    input  logic        app_rd_rdy_i,
    output logic        app_rd_valid_o,
    output logic [15:0] app_rd_payload_o,
    output logic        init_fin_o,
    output logic        proto_err_o,
    output logic [15:0] wr_bursts_o,
    output logic [15:0] rd_bursts_o
);

    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(RD_LATENCY - 2);
    localparam bit          THR       = (THROTTLE != 0);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WR_BURST = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_BURST = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         init_cnt_q, init_cnt_d;
    logic [15:0]         wait_q, wait_d;
    logic                init_fin_q, init_fin_d;
    logic                proto_err_q, proto_err_d;
    logic [MEM_AW-4:0]   blk_q, blk_d;
    logic [3:0]          beat_q, beat_d;
    logic                gap_q, gap_d;
    logic                rd_valid_q, rd_valid_d;
    logic [15:0]         wr_bursts_q, wr_bursts_d;
    logic [15:0]         rd_bursts_q, rd_bursts_d;

    logic                wr_en;
    logic                rd_en;
    logic [MEM_AW-1:0]   mem_addr;
    logic [15:0]         ram_dout_q;
    logic [15:0]         mem_q [2**MEM_AW];

    // Address bits above the RAM depth are dropped on purpose so sizes alias.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^app_addr_i[26:MEM_AW];

    // Bursts are 8-aligned, so base+k never carries out of the low 3 bits.
    assign mem_addr = {blk_q, beat_q[2:0]};
    assign wr_en    = (state_q == S_WR_BURST) && !gap_q;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_d      = wait_q;
        init_fin_d  = init_fin_q;
        proto_err_d = proto_err_q;
        blk_d       = blk_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        rd_valid_d  = 1'b0;
        wr_bursts_d = wr_bursts_q;
        rd_bursts_d = rd_bursts_q;
        rd_en       = 1'b0;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_fin_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (app_wr_valid_i || app_rd_rdy_i) begin
                    blk_d  = app_addr_i[MEM_AW-1:3];
                    beat_d = 4'd0;
                    gap_d  = 1'b0;
                    wait_d = 16'd0;
                    if ((app_addr_i[2:0] != 3'd0) || (app_wr_valid_i && app_rd_rdy_i)) begin
                        proto_err_d = 1'b1;
                    end
                    state_d = app_wr_valid_i ? S_WR_BURST : S_RD_WAIT;
                end
            end
            S_WR_BURST: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    gap_d = THR;
                    if (beat_q[2:0] == 3'd7) begin
                        wr_bursts_d = wr_bursts_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            S_RD_WAIT: begin
                // Beat 0 is fetched in the last wait cycle so it shows at RD_LATENCY.
                if (wait_q == WAIT_LAST) begin
                    rd_en      = 1'b1;
                    rd_valid_d = 1'b1;
                    beat_d     = 4'd1;
                    state_d    = S_RD_BURST;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_RD_BURST: begin
                if (beat_q == 4'd8) begin
                    rd_bursts_d = rd_bursts_q + 16'd1;
                    state_d     = S_IDLE;
                end else if (!(THR && rd_valid_q)) begin
                    rd_en      = 1'b1;
                    rd_valid_d = 1'b1;
                    beat_d     = beat_q + 4'd1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= 16'd0;
            wait_q      <= 16'd0;
            init_fin_q  <= 1'b0;
            proto_err_q <= 1'b0;
            blk_q       <= '0;
            beat_q      <= 4'd0;
            gap_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_bursts_q <= 16'd0;
            rd_bursts_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_q      <= wait_d;
            init_fin_q  <= init_fin_d;
            proto_err_q <= proto_err_d;
            blk_q       <= blk_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            rd_valid_q  <= rd_valid_d;
            wr_bursts_q <= wr_bursts_d;
            rd_bursts_q <= rd_bursts_d;
        end
    end

    // RAM array and its output register carry no reset so they map to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[mem_addr] <= app_wr_payload_i;
        end
        if (rd_en) begin
            ram_dout_q <= mem_q[mem_addr];
        end
    end

    assign app_wr_rdy_o     = wr_en;
    assign app_rd_valid_o   = rd_valid_q;
    assign app_rd_payload_o = rd_valid_q ? ram_dout_q : 16'd0;
    assign init_fin_o       = init_fin_q;
    assign proto_err_o      = proto_err_q;
    assign wr_bursts_o      = wr_bursts_q;
    assign rd_bursts_o      = rd_bursts_q;

endmodule

`default_nettype wire

// File: tb/tb_app_mem_responder.sv
// ============================================================================
// tb_app_mem_responder : scoreboard bench for app_mem_responder (two throttle variants)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_app_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [26:0] addr     [2];
    logic        wr_valid [2];
    logic        rd_rdy   [2];
    logic [15:0] wpay     [2];
    logic        wr_rdy   [2];
    logic        rd_valid [2];
    logic        init_fin [2];
    logic        perr     [2];
    logic [15:0] rpay     [2];
    logic [15:0] wrb      [2];
    logic [15:0] rdb      [2];
    logic        prev_rv  [2];
    logic        prev_wr  [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];

    always #5 clk = ~clk;

    app_mem_responder #(.MEM_AW(10), .INIT_CYCLES(64), .RD_LATENCY(2), .THROTTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .app_addr_i(addr[0]),
        .app_wr_valid_i(wr_valid[0]), .app_wr_rdy_o(wr_rdy[0]), .app_wr_payload_i(wpay[0]),
        .app_rd_rdy_i(rd_rdy[0]), .app_rd_valid_o(rd_valid[0]), .app_rd_payload_o(rpay[0]),
        .init_fin_o(init_fin[0]), .proto_err_o(perr[0]),
        .wr_bursts_o(wrb[0]), .rd_bursts_o(rdb[0])
    );

    app_mem_responder #(.MEM_AW(10), .INIT_CYCLES(16), .RD_LATENCY(2), .THROTTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .app_addr_i(addr[1]),
        .app_wr_valid_i(wr_valid[1]), .app_wr_rdy_o(wr_rdy[1]), .app_wr_payload_i(wpay[1]),
        .app_rd_rdy_i(rd_rdy[1]), .app_rd_valid_o(rd_valid[1]), .app_rd_payload_o(rpay[1]),
        .init_fin_o(init_fin[1]), .proto_err_o(perr[1]),
        .wr_bursts_o(wrb[1]), .rd_bursts_o(rdb[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected word per read beat; throttled DUT must never repeat strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (rd_valid[s]) begin
                    if (s == 0) begin
                        if (exp0.size() == 0) check("rd_unexpected0", 1, 0);
                        else check("rd_data0", {16'd0, rpay[0]}, {16'd0, exp0.pop_front()});
                    end else begin
                        if (exp1.size() == 0) check("rd_unexpected1", 1, 0);
                        else check("rd_data1", {16'd0, rpay[1]}, {16'd0, exp1.pop_front()});
                        check("thr_rd_gap", {31'd0, prev_rv[1]}, 0);
                    end
                end
                if (s == 1 && wr_rdy[1]) check("thr_wr_gap", {31'd0, prev_wr[1]}, 0);
                prev_rv[s] = rd_valid[s];
                prev_wr[s] = wr_rdy[s];
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                prev_rv[s] = 1'b0;
                prev_wr[s] = 1'b0;
            end
        end
    end

    task automatic push_exp(input int s, input logic [15:0] v0, input logic [15:0] inc);
        for (int k = 0; k < 8; k++) begin
            if (s == 0) exp0.push_back(16'(v0 + inc * 16'(k)));
            else        exp1.push_back(16'(v0 + inc * 16'(k)));
        end
    endtask

    task automatic do_write(input int s, input logic [26:0] a, input logic [15:0] v0,
                            input logic [15:0] inc, input int nb, input bit with_rd);
        int beats = 0;
        int cyc   = 0;
        @(negedge clk);
        addr[s]     = a;
        wr_valid[s] = 1'b1;
        if (with_rd) rd_rdy[s] = 1'b1;
        while (beats < nb && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (wr_rdy[s]) begin
                if (beats == 0) check("wr_first_rdy", cyc, 1);
                wpay[s]     = 16'(v0 + inc * 16'(beats));
                wr_valid[s] = 1'b0;
                beats++;
            end
        end
        if (beats < nb) check("wr_timeout", beats, nb);
    endtask

    task automatic do_read(input int s, input logic [26:0] a, input bit pre);
        int cyc   = 0;
        int beats = 0;
        if (!pre) begin
            @(negedge clk);
            addr[s]   = a;
            rd_rdy[s] = 1'b1;
        end
        while (!rd_valid[s] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        rd_rdy[s] = 1'b0;
        if (!rd_valid[s]) begin
            check("rd_timeout", 0, 1);
        end else begin
            if (!pre) check("rd_latency", cyc, 2);
            beats = 1;
            while (beats < 8 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (rd_valid[s]) beats++;
            end
            check("rd_beats", beats, 8);
            @(negedge clk);
            check("rd_valid_after_last", {31'd0, rd_valid[s]}, 0);
        end
    endtask

    task automatic check_reset(input int s);
        check("rst_wr_rdy",   {31'd0, wr_rdy[s]},   0);
        check("rst_rd_valid", {31'd0, rd_valid[s]}, 0);
        check("rst_rd_pay",   {16'd0, rpay[s]},     0);
        check("rst_init_fin", {31'd0, init_fin[s]}, 0);
        check("rst_perr",     {31'd0, perr[s]},     0);
        check("rst_wrb",      {16'd0, wrb[s]},      0);
        check("rst_rdb",      {16'd0, rdb[s]},      0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; wr_valid[s] = 1'b0; rd_rdy[s] = 1'b0; wpay[s] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);

        // Init window: init_fin low for cycles 0..63, write request ignored meanwhile.
        rst_n = 1'b1;
        for (int k = 0; k < 64; k++) begin
            check("init_fin_low", {31'd0, init_fin[0]}, 0);
            if (k >= 2 && k < 10) check("wr_rdy_in_init", {31'd0, wr_rdy[0]}, 0);
            wr_valid[0] = (k >= 1 && k < 10);
            @(negedge clk);
        end
        check("init_fin_high", {31'd0, init_fin[0]}, 1);
        check("init_fin1_high", {31'd0, init_fin[1]}, 1);

        // Basic write then read.
        do_write(0, 27'h10, 16'h1000, 16'd1, 8, 1'b0);
        push_exp(0, 16'h1000, 16'd1);
        do_read(0, 27'h10, 1'b0);
        check("wrb_t2", {16'd0, wrb[0]}, 1);
        check("rdb_t2", {16'd0, rdb[0]}, 1);
        check("perr_t2", {31'd0, perr[0]}, 0);

        // Aliasing above MEM_AW.
        do_write(0, 27'h000_0000, 16'h5A01, 16'd0, 8, 1'b0);
        do_write(0, 27'h400_0000, 16'h5329, 16'd0, 8, 1'b0);
        do_write(0, 27'h000_0400, 16'hAAAA, 16'd0, 8, 1'b0);
        push_exp(0, 16'hAAAA, 16'd0);
        do_read(0, 27'h0, 1'b0);
        do_write(0, 27'h000_0000, 16'h5A01, 16'd0, 8, 1'b0);
        do_write(0, 27'h400_0000, 16'h5329, 16'd0, 8, 1'b0);
        push_exp(0, 16'h5329, 16'd0);
        do_read(0, 27'h0, 1'b0);
        check("wrb_t3", {16'd0, wrb[0]}, 6);
        check("rdb_t3", {16'd0, rdb[0]}, 3);

        // Simultaneous requests: write first, then the held read sees the new data.
        do_write(0, 27'h20, 16'hC0DE, 16'd3, 8, 1'b1);
        push_exp(0, 16'hC0DE, 16'd3);
        do_read(0, 27'h20, 1'b1);
        check("perr_t4", {31'd0, perr[0]}, 1);
        check("wrb_t4", {16'd0, wrb[0]}, 7);
        check("rdb_t4", {16'd0, rdb[0]}, 4);

        // Throttled DUT: aligned burst, then misaligned request aligned down.
        do_write(1, 27'h10, 16'h2000, 16'd1, 8, 1'b0);
        push_exp(1, 16'h2000, 16'd1);
        do_read(1, 27'h10, 1'b0);
        check("perr_t5a", {31'd0, perr[1]}, 0);
        do_write(1, 27'h13, 16'h3000, 16'd1, 8, 1'b0);
        check("perr_t5b", {31'd0, perr[1]}, 1);
        push_exp(1, 16'h3000, 16'd1);
        do_read(1, 27'h10, 1'b0);
        check("wrb_t5", {16'd0, wrb[1]}, 2);
        check("rdb_t5", {16'd0, rdb[1]}, 2);

        // Reset mid-burst after beat 3.
        do_write(0, 27'h30, 16'h6000, 16'd1, 8, 1'b0);
        do_write(0, 27'h30, 16'h7000, 16'd1, 4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!init_fin[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reinit_cycles", cyc, 64);
        for (int k = 0; k < 8; k++) exp0.push_back(k < 4 ? 16'(16'h7000 + k) : 16'(16'h6000 + k));
        do_read(0, 27'h30, 1'b0);
        check("wrb_t6", {16'd0, wrb[0]}, 0);
        check("rdb_t6", {16'd0, rdb[0]}, 1);

        repeat (4) @(negedge clk);
        check("sb0_empty", exp0.size(), 0);
        check("sb1_empty", exp1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
